// File: rtl/pipe_reg_skid_if.sv
// Handshake bundle for one pipeline stage: upstream valid/ready/data,
// downstream valid/ready/data, and the occupancy count.
// The slave modport is the stage's view. The master modport is the
// view of whatever drives and observes the stage.
interface pipe_reg_skid_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       level;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  level
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output level
    );
endinterface

// File: rtl/pipe_reg_skid.sv
// Pipeline stage register with a valid/ready handshake.
// With SKID_EN=1 a second (skid) entry is added, so in_ready depends only
// on held state and never on out_ready.
// Flush empties the stage. level reports how many entries are held.
module pipe_reg_skid #(
    parameter int unsigned      WIDTH   = 32,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    parameter bit               SKID_EN = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    pipe_reg_skid_if.slave     bus
);

    // Encoding doubles as the level output.
    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StTwo   = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic             in_rdy;
    logic             in_x;
    logic             out_x;
    logic             main_load;
    logic             main_from_skid;

    // Ready: registered-state decode with skid, pass-through of out_ready without.
    always_comb begin
        if (SKID_EN) begin
            in_rdy = (state_q != StTwo);
        end else begin
            in_rdy = (state_q == StEmpty) || bus.out_ready;
        end
    end

    assign in_x          = bus.in_valid & in_rdy;
    assign out_x         = (state_q != StEmpty) & bus.out_ready;
    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = (state_q != StEmpty);
    assign bus.out_data  = main_q;
    assign bus.level     = state_q;

    // Next state and main-register load selection; flush overrides all moves.
    always_comb begin
        state_d        = state_q;
        main_load      = 1'b0;
        main_from_skid = 1'b0;
        unique case (state_q)
            StEmpty: begin
                if (in_x) begin
                    state_d   = StOne;
                    main_load = 1'b1;
                end
            end
            StOne: begin
                if (in_x && out_x) begin
                    main_load = 1'b1;
                end else if (in_x) begin
                    // Unreachable without a skid entry: in_ready is low here.
                    state_d = SKID_EN ? StTwo : StOne;
                end else if (out_x) begin
                    state_d = StEmpty;
                end
            end
            StTwo: begin
                if (out_x) begin
                    state_d        = StOne;
                    main_load      = 1'b1;
                    main_from_skid = 1'b1;
                end
            end
            default: state_d = StEmpty;
        endcase
        if (flush) begin
            state_d   = StEmpty;
            main_load = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StEmpty;
        end else begin
            state_q <= state_d;
        end
    end

    // Main register; loads only on a transfer, so idle in_data never reaches it.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_q <= RST_VAL;
        end else if (main_load) begin
            main_q <= main_from_skid ? skid_q : bus.in_data;
        end
    end

    generate
        if (SKID_EN) begin : g_skid
            logic skid_load;
            assign skid_load = (state_q == StOne) && in_x && !out_x && !flush;

            // Skid register catches the payload that arrives while main is stalled.
            always_ff @(posedge clk) begin
                if (rst) begin
                    skid_q <= RST_VAL;
                end else if (skid_load) begin
                    skid_q <= bus.in_data;
                end
            end
        end else begin : g_no_skid
            assign skid_q = RST_VAL;
        end
    endgenerate

endmodule

// File: tb/tb_pipe_reg_skid.sv
// Bench for pipe_reg_skid: one instance with the skid entry and one without,
// directed scenarios followed by randomized traffic against a queue model.
module tb_pipe_reg_skid;

    localparam int unsigned   W   = 32;
    localparam logic [W-1:0]  RV  = 32'hDEAD_BEEF;

    logic clk;
    logic rst;
    logic flush1;
    logic flush0;
    int   n_tests;
    int   n_fail;

    pipe_reg_skid_if #(.WIDTH(W)) b1 ();
    pipe_reg_skid_if #(.WIDTH(W)) b0 ();

    pipe_reg_skid #(.WIDTH(W), .RST_VAL(RV), .SKID_EN(1'b1)) dut1 (
        .clk   (clk),
        .rst   (rst),
        .flush (flush1),
        .bus   (b1)
    );

    pipe_reg_skid #(.WIDTH(W), .RST_VAL(RV), .SKID_EN(1'b0)) dut0 (
        .clk   (clk),
        .rst   (rst),
        .flush (flush0),
        .bus   (b0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    task automatic idle_inputs();
        b1.in_valid = 1'b0; b1.in_data = '0; b1.out_ready = 1'b0; flush1 = 1'b0;
        b0.in_valid = 1'b0; b0.in_data = '0; b0.out_ready = 1'b0; flush0 = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_tests += 8;
        if (b1.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst1_out_valid got=%b exp=0", b1.out_valid); end
        if (b1.level !== 2'd0) begin n_fail++; $display("FAIL rst1_level got=%0d exp=0", b1.level); end
        if (b1.out_data !== RV) begin n_fail++; $display("FAIL rst1_out_data got=%h exp=%h", b1.out_data, RV); end
        if (b1.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst1_in_ready got=%b exp=1", b1.in_ready); end
        if (b0.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst0_out_valid got=%b exp=0", b0.out_valid); end
        if (b0.level !== 2'd0) begin n_fail++; $display("FAIL rst0_level got=%0d exp=0", b0.level); end
        if (b0.out_data !== RV) begin n_fail++; $display("FAIL rst0_out_data got=%h exp=%h", b0.out_data, RV); end
        if (b0.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst0_in_ready got=%b exp=1", b0.in_ready); end
    endtask

    // Full-rate streaming through both variants.
    task automatic test_stream();
        do_reset();
        for (int i = 0; i <= 8; i++) begin
            @(negedge clk);
            if (i > 0) begin
                n_tests += 4;
                if (b1.out_data !== W'(i) || b1.out_valid !== 1'b1) begin
                    n_fail++; $display("FAIL stream1_data i=%0d got=%h/%b exp=%h/1", i, b1.out_data, b1.out_valid, i);
                end
                if (b1.level !== 2'd1) begin n_fail++; $display("FAIL stream1_level i=%0d got=%0d exp=1", i, b1.level); end
                if (b0.out_data !== W'(i) || b0.out_valid !== 1'b1) begin
                    n_fail++; $display("FAIL stream0_data i=%0d got=%h/%b exp=%h/1", i, b0.out_data, b0.out_valid, i);
                end
                if (b0.level !== 2'd1) begin n_fail++; $display("FAIL stream0_level i=%0d got=%0d exp=1", i, b0.level); end
            end
            b1.out_ready = 1'b1; b0.out_ready = 1'b1;
            b1.in_valid = (i < 8); b0.in_valid = (i < 8);
            b1.in_data = W'(i + 1); b0.in_data = W'(i + 1);
        end
        @(negedge clk);
        n_tests += 2;
        if (b1.level !== 2'd0) begin n_fail++; $display("FAIL stream1_drain got=%0d exp=0", b1.level); end
        if (b0.level !== 2'd0) begin n_fail++; $display("FAIL stream0_drain got=%0d exp=0", b0.level); end
    endtask

    // Fill main and skid with A then B while downstream is stalled.
    task automatic fill_ab();
        @(negedge clk);
        b1.in_valid = 1'b1; b1.in_data = 32'hA; b1.out_ready = 1'b0;
        @(negedge clk);
        b1.in_data = 32'hB;
        @(negedge clk);
    endtask

    task automatic test_skid();
        do_reset();
        @(negedge clk);
        b1.in_valid = 1'b1; b1.in_data = 32'hA; b1.out_ready = 1'b0;
        @(negedge clk);
        n_tests += 2;
        if (b1.out_data !== 32'hA || b1.level !== 2'd1) begin
            n_fail++; $display("FAIL skid_one got=%h/%0d exp=a/1", b1.out_data, b1.level);
        end
        if (b1.in_ready !== 1'b1) begin n_fail++; $display("FAIL skid_one_ready got=%b exp=1", b1.in_ready); end
        b1.in_data = 32'hB;
        @(negedge clk);
        n_tests += 3;
        if (b1.level !== 2'd2) begin n_fail++; $display("FAIL skid_two_level got=%0d exp=2", b1.level); end
        if (b1.in_ready !== 1'b0) begin n_fail++; $display("FAIL skid_two_ready got=%b exp=0", b1.in_ready); end
        if (b1.out_data !== 32'hA) begin n_fail++; $display("FAIL skid_two_hold got=%h exp=a", b1.out_data); end
        b1.in_valid = 1'b0; b1.in_data = 32'hFFFF_FFFF; b1.out_ready = 1'b1;
        @(negedge clk);
        n_tests += 2;
        if (b1.out_data !== 32'hB || b1.level !== 2'd1) begin
            n_fail++; $display("FAIL skid_pop_b got=%h/%0d exp=b/1", b1.out_data, b1.level);
        end
        if (b1.in_ready !== 1'b1) begin n_fail++; $display("FAIL skid_pop_ready got=%b exp=1", b1.in_ready); end
        @(negedge clk);
        n_tests += 1;
        if (b1.out_valid !== 1'b0 || b1.level !== 2'd0) begin
            n_fail++; $display("FAIL skid_empty got=%b/%0d exp=0/0", b1.out_valid, b1.level);
        end
    endtask

    task automatic test_flush();
        do_reset();
        fill_ab();
        flush1 = 1'b1; b1.in_valid = 1'b1; b1.in_data = 32'hC; b1.out_ready = 1'b0;
        @(negedge clk);
        flush1 = 1'b0; b1.in_valid = 1'b0; b1.out_ready = 1'b1;
        n_tests += 2;
        if (b1.level !== 2'd0 || b1.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL flush_empty got=%0d/%b exp=0/0", b1.level, b1.out_valid);
        end
        if (b1.in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_ready got=%b exp=1", b1.in_ready); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_tests++;
            if (b1.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_no_c i=%0d got=%b exp=0", i, b1.out_valid); end
        end
    endtask

    task automatic test_rst_midstream();
        do_reset();
        fill_ab();
        rst = 1'b1; b1.in_valid = 1'b1; b1.in_data = 32'hC; b1.out_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0; b1.in_valid = 1'b0;
        @(negedge clk);
        n_tests += 2;
        if (b1.level !== 2'd0 || b1.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_empty got=%0d/%b exp=0/0", b1.level, b1.out_valid);
        end
        if (b1.out_data !== RV) begin n_fail++; $display("FAIL rstmid_data got=%h exp=%h", b1.out_data, RV); end
    endtask

    task automatic test_no_skid();
        do_reset();
        @(negedge clk);
        b0.in_valid = 1'b1; b0.in_data = 32'h11; b0.out_ready = 1'b0;
        @(negedge clk);
        b0.in_data = 32'h22;
        #1;
        n_tests += 2;
        if (b0.in_ready !== 1'b0) begin n_fail++; $display("FAIL noskid_stall_ready got=%b exp=0", b0.in_ready); end
        if (b0.out_data !== 32'h11) begin n_fail++; $display("FAIL noskid_hold got=%h exp=11", b0.out_data); end
        b0.out_ready = 1'b1;
        #1;
        n_tests++;
        if (b0.in_ready !== 1'b1) begin n_fail++; $display("FAIL noskid_pass_ready got=%b exp=1", b0.in_ready); end
        @(negedge clk);
        b0.in_valid = 1'b0;
        n_tests++;
        if (b0.out_data !== 32'h22 || b0.level !== 2'd1 || b0.out_valid !== 1'b1) begin
            n_fail++; $display("FAIL noskid_replace got=%h/%0d exp=22/1", b0.out_data, b0.level);
        end
        @(negedge clk);
        n_tests++;
        if (b0.level !== 2'd0) begin n_fail++; $display("FAIL noskid_drain got=%0d exp=0", b0.level); end
    endtask

    // Random traffic on both variants, each checked against a FIFO of accepted payloads.
    task automatic test_random();
        logic [W-1:0] q1[$];
        logic [W-1:0] q0[$];
        int unsigned  p_in;
        int unsigned  p_out;
        logic [W-1:0] d1, d0;
        logic         e_rdy, e_val;
        do_reset();
        p_in = 50; p_out = 50;
        for (int c = 0; c < 10000 && n_fail < 40; c++) begin
            @(negedge clk);
            if (c % 1000 == 0) begin
                p_in  = $urandom_range(95, 20);
                p_out = $urandom_range(95, 20);
            end
            d1 = $urandom; d0 = $urandom;
            b1.in_valid  = ($urandom_range(99) < p_in);
            b1.in_data   = b1.in_valid ? d1 : 'x;
            b1.out_ready = ($urandom_range(99) < p_out);
            flush1       = ($urandom_range(63) == 0);
            b0.in_valid  = ($urandom_range(99) < p_in);
            b0.in_data   = b0.in_valid ? d0 : 'x;
            b0.out_ready = ($urandom_range(99) < p_out);
            flush0       = ($urandom_range(63) == 0);
            #1;
            // Skid variant: accepts while fewer than two entries are held.
            e_rdy = (q1.size() < 2);
            e_val = (q1.size() != 0);
            n_tests += 3;
            if (b1.in_ready !== e_rdy) begin n_fail++; $display("FAIL rnd1_in_ready c=%0d got=%b exp=%b", c, b1.in_ready, e_rdy); end
            if (b1.out_valid !== e_val) begin n_fail++; $display("FAIL rnd1_out_valid c=%0d got=%b exp=%b", c, b1.out_valid, e_val); end
            if (b1.level !== 2'(q1.size())) begin n_fail++; $display("FAIL rnd1_level c=%0d got=%0d exp=%0d", c, b1.level, q1.size()); end
            if (e_val) begin
                n_tests++;
                if (b1.out_data !== q1[0]) begin n_fail++; $display("FAIL rnd1_out_data c=%0d got=%h exp=%h", c, b1.out_data, q1[0]); end
            end
            if (flush1) begin
                q1.delete();
            end else begin
                if (e_val && b1.out_ready) void'(q1.pop_front());
                if (b1.in_valid && e_rdy) q1.push_back(d1);
            end
            // No-skid variant: accepts when empty or when the held entry leaves now.
            e_val = (q0.size() != 0);
            e_rdy = !e_val || b0.out_ready;
            n_tests += 3;
            if (b0.in_ready !== e_rdy) begin n_fail++; $display("FAIL rnd0_in_ready c=%0d got=%b exp=%b", c, b0.in_ready, e_rdy); end
            if (b0.out_valid !== e_val) begin n_fail++; $display("FAIL rnd0_out_valid c=%0d got=%b exp=%b", c, b0.out_valid, e_val); end
            if (b0.level !== 2'(q0.size())) begin n_fail++; $display("FAIL rnd0_level c=%0d got=%0d exp=%0d", c, b0.level, q0.size()); end
            if (e_val) begin
                n_tests++;
                if (b0.out_data !== q0[0]) begin n_fail++; $display("FAIL rnd0_out_data c=%0d got=%h exp=%h", c, b0.out_data, q0[0]); end
            end
            if (flush0) begin
                q0.delete();
            end else begin
                if (e_val && b0.out_ready) void'(q0.pop_front());
                if (b0.in_valid && e_rdy) q0.push_back(d0);
            end
        end
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b1;
        idle_inputs();
        test_reset();
        test_stream();
        test_skid();
        test_flush();
        test_rst_midstream();
        test_no_skid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
